// File: rtl/dreq_rd_splitter_pkg.sv
// Shared types and constants for the read-request splitter: descriptor/chunk
// layout, default widths and the splitter state encoding.
package dreq_rd_splitter_pkg;

    localparam int DEF_PMTU_BYTES = 4096;
    localparam int DEF_ADDR_BITS  = 48;
    localparam int DEF_LEN_BITS   = 28;
    localparam int DEST_BITS      = 4;
    localparam int PID_BITS       = 6;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] vaddr;
        logic [DEF_LEN_BITS-1:0]  len;
        logic [DEST_BITS-1:0]     dest;
        logic [PID_BITS-1:0]      pid;
        logic                     last;
    } rd_split_req_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_t;

    // Flat width of a descriptor/chunk for a given address and length width.
    function automatic int req_width(input int addr_bits, input int len_bits);
        return addr_bits + len_bits + DEST_BITS + PID_BITS + 1;
    endfunction

endpackage

// File: rtl/dreq_rd_splitter_len_calc.sv
// Combinational chunk-length calculator: clen = min(rem, lim) and last flag.
// Macro RD_SPLIT_ALIGN_EN makes lim stop at the next PMTU-aligned address.
module rd_split_len_calc
    import dreq_rd_splitter_pkg::*;
#(
    parameter int PMTU_BYTES = DEF_PMTU_BYTES,
    parameter int LEN_BITS   = DEF_LEN_BITS
) (
`ifdef RD_SPLIT_ALIGN_EN
    input  logic [$clog2(PMTU_BYTES)-1:0] addr_off,
`endif
    input  logic [LEN_BITS-1:0]           rem,
    output logic [LEN_BITS-1:0]           clen,
    output logic                          last
);

    logic [LEN_BITS-1:0] lim_s;

    // Limit for this chunk, then clamp the remaining length against it.
    always_comb begin
`ifdef RD_SPLIT_ALIGN_EN
        lim_s = LEN_BITS'(PMTU_BYTES) - LEN_BITS'(addr_off);
`else
        lim_s = LEN_BITS'(PMTU_BYTES);
`endif
        if (rem <= lim_s) begin
            clen = rem;
            last = 1'b1;
        end else begin
            clen = lim_s;
            last = 1'b0;
        end
    end

endmodule

// File: rtl/dreq_rd_splitter.sv
// Splits one read descriptor at a time into PMTU-bounded sub-requests.
// Optional macro RD_SPLIT_ALIGN_EN: align chunk boundaries to PMTU addresses.
module dreq_rd_splitter
    import dreq_rd_splitter_pkg::*;
#(
    parameter int PMTU_BYTES = DEF_PMTU_BYTES,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int LEN_BITS   = DEF_LEN_BITS,
    localparam int REQ_W     = req_width(ADDR_BITS, LEN_BITS)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_req_valid,
    output logic             s_req_ready,
    input  logic [REQ_W-1:0] s_req_data,
    output logic             m_req_valid,
    input  logic             m_req_ready,
    output logic [REQ_W-1:0] m_req_data,
    output logic             busy
);

    localparam int PID_LO  = 1;
    localparam int DEST_LO = PID_LO + PID_BITS;
    localparam int LEN_LO  = DEST_LO + DEST_BITS;
    localparam int ADDR_LO = LEN_LO + LEN_BITS;

    logic [ADDR_BITS-1:0] in_vaddr_s;
    logic [LEN_BITS-1:0]  in_len_s;
    logic [DEST_BITS-1:0] in_dest_s;
    logic [PID_BITS-1:0]  in_pid_s;
    logic                 unused_in_last_s;

    split_state_t         state_r;
    logic [ADDR_BITS-1:0] cur_addr_r;
    logic [LEN_BITS-1:0]  rem_r;
    logic [DEST_BITS-1:0] dest_r;
    logic [PID_BITS-1:0]  pid_r;
    logic [LEN_BITS-1:0]  out_len_r;
    logic                 out_last_r;
    logic                 m_valid_r;
    logic                 s_ready_r;
    logic                 busy_r;

    logic [ADDR_BITS-1:0] calc_addr_s;
    logic [LEN_BITS-1:0]  calc_rem_s;
    logic [LEN_BITS-1:0]  calc_len_s;
    logic                 calc_last_s;
    logic                 accept_s;
    logic                 fire_s;

    assign in_vaddr_s       = s_req_data[ADDR_LO +: ADDR_BITS];
    assign in_len_s         = s_req_data[LEN_LO +: LEN_BITS];
    assign in_dest_s        = s_req_data[DEST_LO +: DEST_BITS];
    assign in_pid_s         = s_req_data[PID_LO +: PID_BITS];
    assign unused_in_last_s = s_req_data[0];

    assign accept_s = s_req_valid & s_ready_r;
    assign fire_s   = m_valid_r & m_req_ready;

    // Next chunk source: the new descriptor when idle, else advance past the shown chunk.
    always_comb begin
        if (state_r == ST_SPLIT) begin
            calc_addr_s = cur_addr_r + ADDR_BITS'(out_len_r);
            calc_rem_s  = rem_r - out_len_r;
        end else begin
            calc_addr_s = in_vaddr_s;
            calc_rem_s  = in_len_s;
        end
    end

    rd_split_len_calc #(
        .PMTU_BYTES (PMTU_BYTES),
        .LEN_BITS   (LEN_BITS)
    ) u_len_calc (
`ifdef RD_SPLIT_ALIGN_EN
        .addr_off (calc_addr_s[$clog2(PMTU_BYTES)-1:0]),
`endif
        .rem      (calc_rem_s),
        .clen     (calc_len_s),
        .last     (calc_last_s)
    );

    // Splitter FSM; every output comes straight from a register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            cur_addr_r <= {ADDR_BITS{1'b0}};
            rem_r      <= {LEN_BITS{1'b0}};
            dest_r     <= {DEST_BITS{1'b0}};
            pid_r      <= {PID_BITS{1'b0}};
            out_len_r  <= {LEN_BITS{1'b0}};
            out_last_r <= 1'b0;
            m_valid_r  <= 1'b0;
            s_ready_r  <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_SPLIT;
                        cur_addr_r <= calc_addr_s;
                        rem_r      <= calc_rem_s;
                        dest_r     <= in_dest_s;
                        pid_r      <= in_pid_s;
                        out_len_r  <= calc_len_s;
                        out_last_r <= calc_last_s;
                        m_valid_r  <= 1'b1;
                        s_ready_r  <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_SPLIT: begin
                    if (fire_s) begin
                        if (out_last_r) begin
                            state_r   <= ST_IDLE;
                            m_valid_r <= 1'b0;
                            s_ready_r <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            cur_addr_r <= calc_addr_s;
                            rem_r      <= calc_rem_s;
                            out_len_r  <= calc_len_s;
                            out_last_r <= calc_last_s;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    m_valid_r <= 1'b0;
                    s_ready_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign m_req_valid = m_valid_r;
    assign s_req_ready = s_ready_r;
    assign busy        = busy_r;
    assign m_req_data  = {cur_addr_r, out_len_r, dest_r, pid_r, out_last_r};

endmodule

// File: tb/tb_dreq_rd_splitter.sv
// Self-checking bench for dreq_rd_splitter: directed scenarios plus random
// descriptors compared against a chunk-list reference model.
module tb_dreq_rd_splitter;
    import dreq_rd_splitter_pkg::*;

    localparam int P = DEF_PMTU_BYTES;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          s_req_valid = 1'b0;
    logic          s_req_ready;
    rd_split_req_t s_req_data = '0;
    logic          m_req_valid;
    logic          m_req_ready = 1'b0;
    logic [$bits(rd_split_req_t)-1:0] m_req_data;
    logic          busy;

    int compared = 0;
    int mismatched = 0;

    dreq_rd_splitter dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    // Reference: walk the descriptor applying the chunking rules directly.
    function automatic void build_chunks(input logic [47:0] va, input logic [27:0] ln,
                                         input logic [3:0] d, input logic [5:0] p,
                                         output rd_split_req_t q[$]);
        logic [47:0] a = va;
        longint rem = ln;
        longint lim, c;
        q = {};
        do begin
`ifdef RD_SPLIT_ALIGN_EN
            lim = P - (a % P);
`else
            lim = P;
`endif
            c = (rem < lim) ? rem : lim;
            q.push_back('{vaddr: a, len: 28'(c), dest: d, pid: p, last: (rem == c)});
            a = a + 48'(c);
            rem = rem - c;
        end while (rem > 0);
    endfunction

    // Feed one descriptor and check every chunk; optional stall or mid-split reset.
    task automatic run_desc(input logic [47:0] va, input logic [27:0] ln, input logic [3:0] d,
                            input logic [5:0] p, input int rdy_pct, input int stall_idx,
                            input int stall_cyc, input int abort_at);
        rd_split_req_t exp_q[$];
        rd_split_req_t got;
        int popped = 0;
        int budget = 0;
        int stall_left = stall_cyc;
        logic rdy;
        build_chunks(va, ln, d, p, exp_q);
        @(negedge aclk);
        while (!s_req_ready && budget < 100) begin
            @(negedge aclk);
            budget++;
        end
        s_req_valid = 1'b1;
        s_req_data  = '{vaddr: va, len: ln, dest: d, pid: p, last: 1'($urandom_range(1))};
        @(negedge aclk);
        s_req_valid = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 2000) begin
            if (popped == abort_at) begin
                m_req_ready = 1'b0;
                areset = 1'b1;
                @(negedge aclk);
                areset = 1'b0;
                compared++;
                if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1 || busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL abort_reset: valid=%b ready=%b busy=%b need 0/1/0",
                             m_req_valid, s_req_ready, busy);
                end
                repeat (3) begin
                    @(negedge aclk);
                    compared++;
                    if (m_req_valid !== 1'b0) begin
                        mismatched++;
                        $display("FAIL abort_no_more_chunks: valid=%b need 0", m_req_valid);
                    end
                end
                return;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            if (popped == stall_idx && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            m_req_ready = rdy;
            got = m_req_data;
            compared++;
            if (m_req_valid !== 1'b1 || got !== exp_q[0] || s_req_ready !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL chunk%0d: valid=%b rdy=%b busy=%b got (%h,%0d,%h,%h,%b) need (%h,%0d,%h,%h,%b)",
                         popped, m_req_valid, s_req_ready, busy, got.vaddr, got.len, got.dest, got.pid,
                         got.last, exp_q[0].vaddr, exp_q[0].len, exp_q[0].dest, exp_q[0].pid, exp_q[0].last);
            end
            @(negedge aclk);
            if (rdy) begin
                void'(exp_q.pop_front());
                popped++;
            end
            budget++;
        end
        m_req_ready = 1'b0;
        compared++;
        if (budget >= 2000 || m_req_valid !== 1'b0 || busy !== 1'b0 || s_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL desc_end: budget=%0d valid=%b busy=%b ready=%b need valid=0 busy=0 ready=1",
                     budget, m_req_valid, busy, s_req_ready);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        compared++;
        if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1 || busy !== 1'b0 || m_req_data !== '0) begin
            mismatched++;
            $display("FAIL reset_state: valid=%b ready=%b busy=%b data=%h need 0/1/0/0",
                     m_req_valid, s_req_ready, busy, m_req_data);
        end
        areset = 1'b0;
    endtask

    task automatic test_basic_split();
        run_desc(48'h1000, 28'd10000, 4'h3, 6'h15, 100, -1, 0, -1);
    endtask

    task automatic test_alignment();
        run_desc(48'h1F00, 28'd512, 4'h1, 6'h02, 100, -1, 0, -1);
    endtask

    task automatic test_zero_len();
        run_desc(48'h40, 28'd0, 4'h7, 6'h3F, 100, -1, 0, -1);
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        run_desc(48'h0, 28'd4096, 4'h2, 6'h01, 100, -1, 0, -1);
        s_req_valid = 1'b1;
        s_req_data  = '{vaddr: 48'h8000, len: 28'd100, dest: 4'h9, pid: 6'h11, last: 1'b0};
        @(negedge aclk);
        s_req_valid = 1'b0;
        while (!m_req_valid && gap < 10) begin
            @(negedge aclk);
            gap++;
        end
        compared++;
        if (gap !== 0) begin
            mismatched++;
            $display("FAIL b2b_latency: extra cycles=%0d need 0", gap);
        end
        m_req_ready = 1'b1;
        @(negedge aclk);
        m_req_ready = 1'b0;
        compared++;
        if (m_req_valid !== 1'b0 || s_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_end: valid=%b ready=%b need 0/1", m_req_valid, s_req_ready);
        end
    endtask

    task automatic test_backpressure();
        run_desc(48'h1000, 28'd10000, 4'hA, 6'h2A, 100, 1, 5, -1);
    endtask

    task automatic test_reset_mid_split();
        run_desc(48'h1000, 28'd10000, 4'h5, 6'h05, 100, -1, 0, 1);
        run_desc(48'h5000, 28'd5000, 4'h6, 6'h06, 100, -1, 0, -1);
    endtask

    task automatic test_random();
        logic [47:0] va;
        logic [27:0] ln;
        for (int i = 0; i < 30; i++) begin
            va = {16'($urandom), 32'($urandom)};
            if (i % 5 == 0) va = 48'hFFFF_FFFF_F000 + 48'($urandom_range(4095));
            if (i % 3 == 0) va[11:0] = 12'hF00 + 12'($urandom_range(255));
            ln = (i % 7 == 0) ? 28'd0 : 28'($urandom_range(20000));
            run_desc(va, ln, 4'($urandom), 6'($urandom), 60, -1, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_split();
        test_alignment();
        test_zero_len();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_split();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
